// File: rtl/spi_mem_ctrl.sv
// ---------------------------------------------------------------------------
// spi_mem_ctrl
//
// Memory controller between the CPU sequencer and an external SPI SRAM
// (23LC512-class: 16-bit address, SPI mode 0). Instruction fetches, byte
// loads and byte stores become single SPI frames: 8-bit opcode, 16-bit
// start address, then data, all MSB first. Each SPI bit takes two system
// clocks. Phase 0 drives mosi with sclk low. Phase 1 raises sclk, and miso
// is sampled at the clock edge that ends phase 1.
//
// Optional build macro: MEM_CTRL_WRITE_PROTECT_EN
//   Adds parameter WP_LIMIT and output wp_fault_out. Stores below WP_LIMIT
//   are dropped without any SPI activity and set the sticky fault flag.
//
// Ports:
//   clk_in              system clock
//   reset_in            asynchronous, active-high reset
//   seq_state_in        sequencer state (decoded only while idle)
//   pc_in               instruction byte address
//   data_addr_in        load/store byte address
//   store_data_in       byte to store
//   mem_busy_out        transaction in progress
//   inst_fetch_done_out one-cycle pulse, inst_out valid
//   data_read_done_out  one-cycle pulse, load_data_out valid
//   inst_out            last fetched instruction (first byte in the MSBs)
//   load_data_out       last loaded byte
//   wp_fault_out        sticky write-protect fault (macro builds only)
//   spi_cs_n_out        SRAM chip select, active low
//   spi_sclk_out        SPI clock, idle low
//   spi_mosi_out        serial data to SRAM
//   spi_miso_in         serial data from SRAM
// ---------------------------------------------------------------------------

package spi_mem_ctrl_pkg;
  typedef enum logic [2:0] {
    STATE_RESET     = 3'd0,
    STATE_FETCH     = 3'd1,
    STATE_DECODE    = 3'd2,
    STATE_EXECUTE   = 3'd3,
    STATE_LOAD_MEM  = 3'd4,
    STATE_STORE_MEM = 3'd5,
    STATE_WRITEBACK = 3'd6,
    STATE_HALT      = 3'd7
  } sys_state_t;
endpackage

module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int unsigned INST_W = 16,
  parameter logic [7:0]  RD_CMD = 8'h03,
  parameter logic [7:0]  WR_CMD = 8'h02
`ifdef MEM_CTRL_WRITE_PROTECT_EN
  ,
  parameter logic [15:0] WP_LIMIT = 16'h0100
`endif
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  sys_state_t        seq_state_in,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       data_addr_in,
  input  logic [7:0]        store_data_in,
  output logic              mem_busy_out,
  output logic              inst_fetch_done_out,
  output logic              data_read_done_out,
  output logic [INST_W-1:0] inst_out,
  output logic [7:0]        load_data_out,
`ifdef MEM_CTRL_WRITE_PROTECT_EN
  output logic              wp_fault_out,
`endif
  output logic              spi_cs_n_out,
  output logic              spi_sclk_out,
  output logic              spi_mosi_out,
  input  logic              spi_miso_in
);

  localparam int unsigned FETCH_BITS = 24 + INST_W;
  localparam int unsigned CNT_W      = $clog2(FETCH_BITS);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(31);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} ctrl_state_e;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_e;

  ctrl_state_e       state_q, state_d;
  op_e               op_q, op_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0]       tx_q, tx_d;        // bits still to send after mosi_q
  logic [INST_W-1:0] rx_q, rx_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [7:0]        load_q, load_d;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
  logic              wp_fault_q, wp_fault_d;
`endif

  logic              req;
  logic [31:0]       frame;
  logic              last_bit;
  logic [INST_W-1:0] rx_next;

  assign last_bit = (op_q == OP_FETCH) ? (bit_cnt_q == FETCH_LAST)
                                       : (bit_cnt_q == BYTE_LAST);
  assign rx_next  = {rx_q[INST_W-2:0], spi_miso_in};

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    inst_done_d = 1'b0;
    data_done_d = 1'b0;
    inst_d      = inst_q;
    load_d      = load_q;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
    wp_fault_d  = wp_fault_q;
`endif
    req         = 1'b0;
    frame       = 32'h0;

    case (state_q)
      S_IDLE: begin
        // Read frames carry zeros in the data slot, which keeps mosi low
        // while the SRAM returns data.
        case (seq_state_in)
          STATE_FETCH: begin
            req   = 1'b1;
            op_d  = OP_FETCH;
            frame = {RD_CMD, pc_in, 8'h00};
          end
          STATE_LOAD_MEM: begin
            req   = 1'b1;
            op_d  = OP_LOAD;
            frame = {RD_CMD, data_addr_in, 8'h00};
          end
          STATE_STORE_MEM: begin
            req   = 1'b1;
            op_d  = OP_STORE;
            frame = {WR_CMD, data_addr_in, store_data_in};
          end
          default: ;
        endcase

        if (req) begin
          state_d   = S_SHIFT;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
          mosi_d    = frame[31];
          tx_d      = {frame[30:0], 1'b0};
`ifdef MEM_CTRL_WRITE_PROTECT_EN
          // A protected store skips the SPI frame entirely; busy still
          // pulses for the single FINISH cycle.
          if (seq_state_in == STATE_STORE_MEM && data_addr_in < WP_LIMIT) begin
            state_d    = S_FINISH;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            wp_fault_d = 1'b1;
          end
`endif
        end
      end

      S_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          // This edge ends phase 1: miso is captured here.
          rx_d    = rx_next;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          if (last_bit) begin
            state_d = S_FINISH;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            case (op_q)
              OP_FETCH: begin
                inst_d      = rx_next;
                inst_done_d = 1'b1;
              end
              OP_LOAD: begin
                load_d      = rx_next[7:0];
                data_done_d = 1'b1;
              end
              default: ;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            mosi_d    = tx_q[31];
            tx_d      = {tx_q[30:0], 1'b0};
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // The shift registers are reset along with the control state, so an
  // abandoned transaction leaves nothing behind.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FETCH;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      inst_q      <= '0;
      load_q      <= '0;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
      wp_fault_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
      inst_q      <= inst_d;
      load_q      <= load_d;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
      wp_fault_q  <= wp_fault_d;
`endif
    end
  end

  assign mem_busy_out        = busy_q;
  assign inst_fetch_done_out = inst_done_q;
  assign data_read_done_out  = data_done_q;
  assign inst_out            = inst_q;
  assign load_data_out       = load_q;
  assign spi_cs_n_out        = cs_n_q;
  assign spi_sclk_out        = sclk_q;
  assign spi_mosi_out        = mosi_q;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
  assign wp_fault_out        = wp_fault_q;
`endif

endmodule
